bp_gselect_param: RTL and testbench
===================================

Name: bp_gselect_param

Overview:
- Parametrised gselect/gshare conditional-branch predictor with a direct-mapped tagged BTB, speculative global history, and history recovery on misprediction.
- Sits between fetch (predict port) and retire (update port) in the branch-prediction subsystem.
- Generalises the fixed 8-bit-history, dual-lane predictor:
  - Configurable history length, PC index bits, BTB depth and index-hash mode.
  - Adds a counter-initialisation sweep, tag-checked BTB lookup and GHR checkpoint/restore.

Parameters:
- GHR_W, 8, global history length in bits (1..12).
- PC_W, 4, PC bits [PC_W+1:2] used in the PHT index.
- BTB_IDX_W, 8, log2 of BTB entries; BTB index is PC[BTB_IDX_W+1:2], tag is PC[31:BTB_IDX_W+2].
- MODE, 0, 0 = gselect, index {GHR, PC[PC_W+1:2]}; 1 = gshare, index PC[GHR_W+PC_W+1:2] XOR {GHR, PC_W'b0}.
- Derived: PHT_IDX_W = GHR_W+PC_W; PHT depth 2^PHT_IDX_W of 2-bit counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once the post-reset sweep completes.
- pred_req  in  1  predict request, sampled only when init_done=1.
- pred_pc  in  32  fetch PC of the request.
- pred_valid  out  1  registered response strobe, one cycle after an accepted request.
- pred_taken  out  1  predicted direction.
- pred_target  out  32  predicted next PC.
- pred_ghr  out  GHR_W  speculative GHR value used for this prediction (checkpoint).
- upd_valid  in  1  retire update strobe.
- upd_pc  in  32  retiring instruction PC.
- upd_is_br  in  1  instruction is a conditional branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved branch target.
- upd_ghr  in  GHR_W  checkpoint returned from pred_ghr.
- upd_mispredict  in  1  direction or target mispredicted.

Behaviour:
- Reset (rst=1 on any edge, including mid-sweep or mid-operation):
  - init_done=0, pred_valid=0, pred_taken=0, pred_target=0, pred_ghr=0, spec GHR=0, sweep counter=0.
- Init FSM states: INIT, RUN.
  - INIT lasts exactly max(2^PHT_IDX_W, 2^BTB_IDX_W) cycles after rst deasserts.
  - Each INIT cycle writes PHT[cnt]=2'b01 (weakly not-taken) and clears BTB valid[cnt] where in range.
  - INIT -> RUN when cnt reaches its last value; init_done rises on the following edge.
  - pred_req and upd_valid are ignored in INIT.
- Predict (RUN, pred_req=1), latency 1:
  - PHT index is formed from the current spec GHR and pred_pc.
  - BTB hit = valid AND tag match.
  - pred_taken = hit AND counter[1].
  - pred_target = pred_taken ? BTB target : pred_pc+4 (32-bit wrap).
  - pred_ghr = spec GHR before any shift.
  - On hit, spec GHR <= {GHR[GHR_W-2:0], pred_taken}; on miss, GHR is unchanged.
  - pred_valid pulses exactly one cycle per accepted request.
- Update (RUN, upd_valid=1), takes effect at the edge:
  - PHT index is formed from upd_ghr (not the spec GHR) and upd_pc.
  - upd_is_br=1:
    - Counter increments if taken and decrements if not, saturating at 3 and 0.
    - BTB[idx] <= {tag, upd_target}, valid=1.
  - upd_is_br=0 with tag match: valid cleared, PHT untouched. With no tag match: no change.
  - upd_mispredict=1 AND upd_is_br=1: spec GHR <= {upd_ghr[GHR_W-2:0], upd_taken}.
  - upd_mispredict=1 AND upd_is_br=0: spec GHR <= upd_ghr.
- Simultaneous predict and update in the same cycle:
  - The prediction reads pre-update PHT/BTB contents.
  - If upd_mispredict=1, recovery overrides the prediction's GHR shift and pred_valid is forced 0 next cycle (request dropped).
  - If upd_mispredict=0, the prediction's shift applies normally.
- GHR_W=1 edge case: the shift degenerates to GHR <= new bit.

Test Plan:
- Reset then idle, GHR_W=4, PC_W=2 -> init_done=0 for 64 cycles, then 1 on cycle 65; 8 updates taken at PC 0x100 then predict 0x100 before that -> pred_taken=0, pred_target=0x104.
- Two taken updates PC 0x40 target 0x800, upd_ghr=0, then predict 0x40 with GHR=0 -> pred_valid next cycle, pred_taken=1, pred_target=0x800, spec GHR becomes 0x1.
- Saturation: 5 taken then 1 not-taken update at the same index -> counter 3 then 2, prediction stays taken; 3 more not-taken -> counter 0, not-taken.
- Tag alias, BTB_IDX_W=8: train 0x0040 taken, predict 0x0440 (same index, different tag) -> miss, taken=0, target=0x0444, GHR unchanged.
- Mispredict recovery: spec GHR=0xA5, upd_mispredict=1, upd_is_br=1, upd_ghr=0x3C, upd_taken=1, with pred_req in the same cycle -> GHR=0x79, pred_valid=0 next cycle.
- rst asserted at sweep cycle 20 -> counter restarts, full sweep length re-elapses before init_done rises.
- MODE=1 gshare: GHR=0x01, PC 0x4 vs 0x44 map per the XOR formula to distinct counters -> independent training results observed.

Source files
------------

// File: rtl/bp_gselect_param.sv
// Parametrised gselect/gshare conditional-branch predictor with a direct-mapped
// tagged BTB, speculative global history and history recovery on mispredict.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_done       high once the post-reset counter/BTB sweep has finished
//   pred_req/pc     fetch-side predict request (accepted only when init_done=1)
//   pred_valid      one-cycle response strobe, one cycle after an accepted request
//   pred_taken      predicted direction
//   pred_target     predicted next PC
//   pred_ghr        speculative history used for this prediction (checkpoint)
//   upd_*           retire-side training and history recovery
module bp_gselect_param #(
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned PC_W      = 4,
  parameter int unsigned BTB_IDX_W = 8,
  parameter int unsigned MODE      = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_is_br,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_mispredict
);

  localparam int unsigned PhtIdxW  = GHR_W + PC_W;
  localparam int unsigned PhtDepth = 1 << PhtIdxW;
  localparam int unsigned BtbDepth = 1 << BTB_IDX_W;
  localparam int unsigned CntW     = (PhtIdxW > BTB_IDX_W) ? PhtIdxW : BTB_IDX_W;
  localparam int unsigned TagW     = 30 - BTB_IDX_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // PHT index: gselect concatenates history above the PC bits, gshare folds the
  // history onto the upper PC bits with XOR.
  function automatic logic [PhtIdxW-1:0] pht_index(input logic [GHR_W-1:0] ghr,
                                                   input logic [31:0] pc);
    if (MODE == 0) begin
      return {ghr, pc[PC_W+1:2]};
    end else begin
      return pc[PhtIdxW+1:2] ^ {ghr, {PC_W{1'b0}}};
    end
  endfunction

  // Widening first keeps the GHR_W=1 case free of a negative slice.
  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] ghr,
                                                 input logic bit_in);
    logic [GHR_W:0] tmp;
    tmp = {ghr, bit_in};
    return tmp[GHR_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              run;

  logic [1:0]        pht_q       [PhtDepth];
  logic              btb_valid_q [BtbDepth];
  logic [TagW-1:0]   btb_tag_q   [BtbDepth];
  logic [31:0]       btb_tgt_q   [BtbDepth];

  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic              pred_valid_q, pred_taken_q;
  logic [31:0]       pred_target_q;
  logic [GHR_W-1:0]  pred_ghr_q;

  logic [PhtIdxW-1:0]   p_idx, u_idx;
  logic [BTB_IDX_W-1:0] p_btb_idx, u_btb_idx;
  logic [TagW-1:0]      p_tag, u_tag;
  logic                 p_hit, p_taken, u_tag_match;
  logic [31:0]          p_target;
  logic                 accept, recover;
  logic [1:0]           u_cnt;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Init FSM: state register, next state, outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = StRun;
      end
      StRun: ;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    run       = (state_q == StRun);
    init_done = run;
  end

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  always_comb begin
    p_idx     = pht_index(ghr_q, pred_pc);
    p_btb_idx = pred_pc[BTB_IDX_W+1:2];
    p_tag     = pred_pc[31:BTB_IDX_W+2];
    p_hit     = btb_valid_q[p_btb_idx] && (btb_tag_q[p_btb_idx] == p_tag);
    p_taken   = p_hit && pht_q[p_idx][1];
    p_target  = p_taken ? btb_tgt_q[p_btb_idx] : pred_pc + 32'd4;

    u_idx       = pht_index(upd_ghr, upd_pc);
    u_btb_idx   = upd_pc[BTB_IDX_W+1:2];
    u_tag       = upd_pc[31:BTB_IDX_W+2];
    u_tag_match = (btb_tag_q[u_btb_idx] == u_tag);
    u_cnt       = pht_q[u_idx];

    accept  = run && pred_req;
    recover = run && upd_valid && upd_mispredict;
  end

  // Recovery from retire wins over the speculative shift of a same-cycle predict.
  always_comb begin
    ghr_d = ghr_q;
    if (recover) begin
      ghr_d = upd_is_br ? ghr_shift(upd_ghr, upd_taken) : upd_ghr;
    end else if (accept && p_hit) begin
      ghr_d = ghr_shift(ghr_q, p_taken);
    end
  end

  // ---------------------------------------------------------------------------
  // Tables: sweep during init, train from retire during run
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        if (32'(cnt_q) < PhtDepth) pht_q[cnt_q[PhtIdxW-1:0]] <= 2'b01;
        if (32'(cnt_q) < BtbDepth) btb_valid_q[cnt_q[BTB_IDX_W-1:0]] <= 1'b0;
      end else if (upd_valid) begin
        if (upd_is_br) begin
          if (upd_taken && u_cnt != 2'b11) pht_q[u_idx] <= u_cnt + 2'b01;
          else if (!upd_taken && u_cnt != 2'b00) pht_q[u_idx] <= u_cnt - 2'b01;
          btb_valid_q[u_btb_idx] <= 1'b1;
          btb_tag_q[u_btb_idx]   <= u_tag;
          btb_tgt_q[u_btb_idx]   <= upd_target;
        end else if (u_tag_match) begin
          btb_valid_q[u_btb_idx] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers and speculative history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_ghr_q    <= '0;
      ghr_q         <= '0;
    end else begin
      pred_valid_q <= accept && !recover;
      if (accept) begin
        pred_taken_q  <= p_taken;
        pred_target_q <= p_target;
        pred_ghr_q    <= ghr_q;
      end
      ghr_q <= ghr_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_ghr    = pred_ghr_q;

endmodule

// File: tb/tb_bp_gselect_param.sv
// Directed bench for bp_gselect_param. Two instances share the request/update
// stimulus: dut_a is a small gselect (GHR 4, PC 2, BTB 6 -> 64-cycle sweep) and
// dut_b a gshare with default sizes (4096-cycle sweep). dut_a is exercised while
// dut_b is still sweeping, so dut_b ignores that traffic.
module tb_bp_gselect_param;

  logic        clk;
  logic        rst;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_br;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [7:0]  upd_ghr;
  logic        upd_mispredict;

  logic        a_init_done, a_pred_valid, a_pred_taken;
  logic [31:0] a_pred_target;
  logic [3:0]  a_pred_ghr;
  logic        b_init_done, b_pred_valid, b_pred_taken;
  logic [31:0] b_pred_target;
  logic [7:0]  b_pred_ghr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_start = 0;
  int n;

  bp_gselect_param #(.GHR_W(4), .PC_W(2), .BTB_IDX_W(6), .MODE(0)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .init_done      (a_init_done),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_valid     (a_pred_valid),
    .pred_taken     (a_pred_taken),
    .pred_target    (a_pred_target),
    .pred_ghr       (a_pred_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_br      (upd_is_br),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_ghr        (upd_ghr[3:0]),
    .upd_mispredict (upd_mispredict)
  );

  bp_gselect_param #(.GHR_W(8), .PC_W(4), .BTB_IDX_W(8), .MODE(1)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .init_done      (b_init_done),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_valid     (b_pred_valid),
    .pred_taken     (b_pred_taken),
    .pred_target    (b_pred_target),
    .pred_ghr       (b_pred_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_br      (upd_is_br),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_ghr        (upd_ghr),
    .upd_mispredict (upd_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] tgt, input logic [7:0] g, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_is_br = br; upd_taken = tk;
    upd_target = tgt; upd_ghr = g; upd_mispredict = mis;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic do_pred(input logic [31:0] pc);
    pred_req = 1'b1; pred_pc = pc;
    tick();
    pred_req = 1'b0;
  endtask

  task automatic exp_a(input string tag, input logic v, input logic t,
                       input logic [31:0] tgt, input logic [3:0] g);
    check({tag, "_valid"},  a_pred_valid,  v);
    check({tag, "_taken"},  a_pred_taken,  t);
    check({tag, "_target"}, a_pred_target, tgt);
    check({tag, "_ghr"},    a_pred_ghr,    g);
  endtask

  task automatic exp_b(input string tag, input logic v, input logic t,
                       input logic [31:0] tgt, input logic [7:0] g);
    check({tag, "_valid"},  b_pred_valid,  v);
    check({tag, "_taken"},  b_pred_taken,  t);
    check({tag, "_target"}, b_pred_target, tgt);
    check({tag, "_ghr"},    b_pred_ghr,    g);
  endtask

  initial begin
    rst = 1'b1; pred_req = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_br = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_ghr = '0; upd_mispredict = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_a_init_done", a_init_done, 1'b0);
    check("rst_a_valid", a_pred_valid, 1'b0);
    check("rst_a_target", a_pred_target, 32'h0);
    check("rst_a_ghr", a_pred_ghr, 4'h0);
    check("rst_b_init_done", b_init_done, 1'b0);
    check("rst_b_ghr", b_pred_ghr, 8'h0);

    // Sweep interrupted at cycle 20; a request during init is ignored
    rst = 1'b0;
    repeat (9) tick();
    do_pred(32'h40);
    check("init_req_ignored", a_pred_valid, 1'b0);
    repeat (10) tick();
    check("init_not_done_20", a_init_done, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t_start = cyc;
    n = 0;
    while (!a_init_done && n < 200) begin
      tick();
      n++;
    end
    check("a_sweep_len", n, 64);

    // --- dut_a: gselect, idx = {ghr[3:0], pc[3:2]}, spec GHR = 0 ---
    do_pred(32'h100);
    exp_a("a_cold", 1'b1, 1'b0, 32'h104, 4'h0);
    tick();
    check("a_valid_pulse", a_pred_valid, 1'b0);

    repeat (2) do_upd(32'h40, 1'b1, 1'b1, 32'h800, 8'h0, 1'b0);
    do_pred(32'h40);                         // hit, counter 3 -> GHR 1
    exp_a("a_trained", 1'b1, 1'b1, 32'h800, 4'h0);

    do_pred(32'h440);                        // same BTB set, other tag
    exp_a("a_alias", 1'b1, 1'b0, 32'h444, 4'h1);
    do_pred(32'h440);
    check("a_alias_ghr_hold", a_pred_ghr, 4'h1);

    // Saturation at PHT idx 1 (PC 0x44, history 0)
    repeat (5) do_upd(32'h44, 1'b1, 1'b1, 32'h900, 8'h0, 1'b0);
    do_upd(32'h44, 1'b1, 1'b0, 32'h900, 8'h0, 1'b1);  // counter 2, GHR <- 0
    do_pred(32'h44);
    exp_a("a_sat_3to2", 1'b1, 1'b1, 32'h900, 4'h0);   // GHR -> 1
    repeat (2) do_upd(32'h44, 1'b1, 1'b0, 32'h900, 8'h0, 1'b0);
    do_upd(32'h44, 1'b1, 1'b0, 32'h900, 8'h0, 1'b1);  // counter 0, GHR <- 0
    do_pred(32'h44);
    exp_a("a_sat_0", 1'b1, 1'b0, 32'h48, 4'h0);

    // Same-cycle predict + non-mispredict update reads pre-update BTB
    do_upd(32'h100, 1'b1, 1'b1, 32'h200, 8'h0, 1'b0);
    pred_req = 1'b1; pred_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_is_br = 1'b0; upd_ghr = 8'h0;
    upd_mispredict = 1'b0;
    tick();
    pred_req = 1'b0; upd_valid = 1'b0;
    exp_a("a_simul_pre", 1'b1, 1'b1, 32'h200, 4'h0);  // GHR -> 1
    do_pred(32'h100);
    exp_a("a_simul_post", 1'b1, 1'b0, 32'h104, 4'h1);

    // Non-branch with tag match invalidates; mispredict restores GHR verbatim
    do_upd(32'h40, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1);
    do_pred(32'h40);
    exp_a("a_nonbr_clear", 1'b1, 1'b0, 32'h44, 4'h0);

    // Same-cycle predict + mispredict: request dropped, GHR = {3[2:0],1} = 7
    pred_req = 1'b1; pred_pc = 32'h44;
    upd_valid = 1'b1; upd_pc = 32'hF00; upd_is_br = 1'b1; upd_taken = 1'b1;
    upd_target = 32'hF10; upd_ghr = 8'h3; upd_mispredict = 1'b1;
    tick();
    pred_req = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    check("a_drop_valid", a_pred_valid, 1'b0);
    do_pred(32'h100);
    exp_a("a_recover", 1'b1, 1'b0, 32'h104, 4'h7);

    // --- dut_b: gshare, idx = pc[13:2] ^ {ghr, 4'b0} ---
    n = 0;
    while (!b_init_done && n < 6000) begin
      tick();
      n++;
    end
    check("b_sweep_len", cyc - t_start, 4096);

    // History 1: PC 0x4 -> idx 0x011, PC 0x44 -> idx 0x001
    repeat (2) do_upd(32'h4, 1'b1, 1'b1, 32'h400, 8'h01, 1'b0);
    do_upd(32'h44, 1'b1, 1'b0, 32'h500, 8'h01, 1'b0);
    do_upd(32'h8, 1'b0, 1'b0, 32'h0, 8'h01, 1'b1);
    do_pred(32'h4);
    exp_b("b_gshare_4", 1'b1, 1'b1, 32'h400, 8'h01);   // GHR -> 0x03
    do_upd(32'h8, 1'b0, 1'b0, 32'h0, 8'h01, 1'b1);
    do_pred(32'h44);
    exp_b("b_gshare_44", 1'b1, 1'b0, 32'h48, 8'h01);

    // Recovery from GHR 0xA5 with checkpoint 0x3C, taken -> 0x79, request dropped
    do_upd(32'h8, 1'b0, 1'b0, 32'h0, 8'hA5, 1'b1);
    pred_req = 1'b1; pred_pc = 32'h4;
    upd_valid = 1'b1; upd_pc = 32'hC; upd_is_br = 1'b1; upd_taken = 1'b1;
    upd_target = 32'h600; upd_ghr = 8'h3C; upd_mispredict = 1'b1;
    tick();
    pred_req = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    check("b_drop_valid", b_pred_valid, 1'b0);
    do_pred(32'h1000);
    exp_b("b_recover", 1'b1, 1'b0, 32'h1004, 8'h79);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
